// File: rtl/search_pkg.sv
// Shared types and constants for the binary-search request stage.
package search_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } req_state_t;

    localparam int unsigned SEARCH_DATA_W   = 8;
    localparam int unsigned SEARCH_ADDR_W   = 5;
    localparam int unsigned HOLD_MIN_CYCLES = 2;

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer plus history flop; emits a registered one-cycle pulse
// on each synchronized rising edge of the raw key.
module key_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic rise
);

    logic sync1_q, sync2_q, sync3_q, rise_q;
    logic rise_d;

    always_comb begin
        rise_d = sync2_q & ~sync3_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            rise_q  <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/search_requester.sv
// Turns a button press into one search request, holds s/A until done, and
// captures the result. Optional WAIT watchdog under SEARCH_REQ_TIMEOUT_EN.
module search_requester
    import search_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = SEARCH_DATA_W,
    parameter int unsigned ADDR_WIDTH     = SEARCH_ADDR_W,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_key,
    input  logic [DATA_WIDTH-1:0] sw_A,
    output logic                  s,
    output logic [DATA_WIDTH-1:0] A,
    input  logic                  done,
    input  logic                  found,
    input  logic [ADDR_WIDTH-1:0] loc,
    output logic                  busy,
    output logic                  res_valid,
    output logic                  res_found,
    output logic [ADDR_WIDTH-1:0] res_loc,
    output logic                  timeout
);

    localparam logic [1:0] DWELL_LAST = 2'(HOLD_MIN_CYCLES - 1);

    logic rise;

    key_sync_edge u_key_sync (
        .clk    (clk),
        .reset  (reset),
        .key_in (start_key),
        .rise   (rise)
    );

    req_state_t            state_q, state_d;
    logic                  s_q, s_d, busy_q, busy_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic                  res_valid_q, res_valid_d, res_found_q, res_found_d;
    logic [ADDR_WIDTH-1:0] res_loc_q, res_loc_d;
    logic [1:0]            dwell_q, dwell_d;
    logic                  timeout_q, timeout_d;

`ifdef SEARCH_REQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        res_valid_d = res_valid_q;
        res_found_d = res_found_q;
        res_loc_d   = res_loc_q;
        dwell_d     = dwell_q;
        timeout_d   = timeout_q;
`ifdef SEARCH_REQ_TIMEOUT_EN
        wd_d        = wd_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise) begin
                    a_d         = sw_A;
                    res_valid_d = 1'b0;
                    res_found_d = 1'b0;
                    res_loc_d   = '0;
                    timeout_d   = 1'b0;
`ifdef SEARCH_REQ_TIMEOUT_EN
                    wd_d        = '0;
`endif
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                dwell_d = '0;
`ifdef SEARCH_REQ_TIMEOUT_EN
                wd_d = wd_q + 1'b1;
`endif
                if (done) begin
                    res_found_d = found;
                    res_loc_d   = loc;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end
`ifdef SEARCH_REQ_TIMEOUT_EN
                // done has priority; the watchdog fires as the count reaches the limit
                else if (wd_q == WD_LAST) begin
                    timeout_d   = 1'b1;
                    res_valid_d = 1'b1;
                    res_found_d = 1'b0;
                    res_loc_d   = '0;
                    state_d     = HOLD;
                end
`endif
            end
            HOLD: begin
                if (dwell_q != DWELL_LAST) dwell_d = dwell_q + 1'b1;
                if (dwell_q == DWELL_LAST && !done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        s_d    = (state_d == WAIT);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            s_q         <= 1'b0;
            busy_q      <= 1'b0;
            a_q         <= '0;
            res_valid_q <= 1'b0;
            res_found_q <= 1'b0;
            res_loc_q   <= '0;
            dwell_q     <= '0;
            timeout_q   <= 1'b0;
`ifdef SEARCH_REQ_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            busy_q      <= busy_d;
            a_q         <= a_d;
            res_valid_q <= res_valid_d;
            res_found_q <= res_found_d;
            res_loc_q   <= res_loc_d;
            dwell_q     <= dwell_d;
            timeout_q   <= timeout_d;
`ifdef SEARCH_REQ_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign s         = s_q;
    assign A         = a_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_found = res_found_q;
    assign res_loc   = res_loc_q;
`ifdef SEARCH_REQ_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule
